// File: rtl/nvdla_csb2cmac_arb.sv
// ---------------------------------------------------------------------------
// nvdla_csb2cmac_arb
// Two-requester CSB arbiter in front of the CMAC register block. Requests from
// req0/req1 are granted round-robin into a single registered request channel.
// An in-order tag FIFO remembers which requester owns each response-expecting
// request, so responses coming back on the shared channel can be routed.
//
// Optional feature: define NVDLA_CSB2CMAC_ARB_TIMEOUT_EN to add a response
// timeout. It synthesises an error response after TIMEOUT_CYC cycles and
// pulses the extra output timeout_err.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   reqN_pvld / reqN_prdy / reqN_pd  : requester N (0,1), 63-bit CSB request
//   csb2cmac_req_*                   : shared downstream request channel
//   cmac2csb_resp_valid / _pd        : shared response channel, no backpressure
//   respN_valid / respN_pd           : routed response to requester N
//   timeout_err                      : timeout pulse (only with the macro)
//   resp_orphan                      : pulse for a response with no owner
// ---------------------------------------------------------------------------
module nvdla_csb2cmac_arb #(
  parameter int OUTST_DEPTH = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        req0_pvld,
  output logic        req0_prdy,
  input  logic [62:0] req0_pd,
  input  logic        req1_pvld,
  output logic        req1_prdy,
  input  logic [62:0] req1_pd,
  output logic        csb2cmac_req_pvld,
  input  logic        csb2cmac_req_prdy,
  output logic [62:0] csb2cmac_req_pd,
  input  logic        cmac2csb_resp_valid,
  input  logic [33:0] cmac2csb_resp_pd,
  output logic        resp0_valid,
  output logic [33:0] resp0_pd,
  output logic        resp1_valid,
  output logic [33:0] resp1_pd,
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        resp_orphan
);

  localparam int PW = $clog2(OUTST_DEPTH);
  localparam int CW = PW + 1;

  logic          r_pvld;
  logic [62:0]   r_pd;
  logic          r_last;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_tags [OUTST_DEPTH];
  logic          r_resp0_valid;
  logic          r_resp1_valid;
  logic [33:0]   r_resp_pd;
  logic          r_orphan;

  logic          w_space;
  logic          w_need0;
  logic          w_need1;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_load;
  logic          w_win;
  logic [62:0]   w_win_pd;
  logic          w_push;
  logic          w_real_pop;
  logic          w_pop;
  logic          w_head;
  logic [33:0]   w_resp_pd;

  // A request needs a response when it is a read or a non-posted write.
  assign w_need0 = ~req0_pd[54] | req0_pd[55];
  assign w_need1 = ~req1_pd[54] | req1_pd[55];

  // Eligibility uses the registered count only, so a pop in this cycle frees
  // a slot for the next cycle, not this one.
  assign w_space = r_count < CW'(OUTST_DEPTH);
  assign w_elig0 = req0_pvld & (~w_need0 | w_space);
  assign w_elig1 = req1_pvld & (~w_need1 | w_space);

  assign w_load   = (~r_pvld | csb2cmac_req_prdy) & (w_elig0 | w_elig1);
  // On a tie the requester not granted last wins; otherwise the lone one.
  assign w_win    = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  assign w_win_pd = w_win ? req1_pd : req0_pd;
  assign w_push   = w_load & (w_win ? w_need1 : w_need0);

  // Ready is held low during reset even though the state already looks idle.
  assign req0_prdy = nvdla_core_rstn & w_load & ~w_win;
  assign req1_prdy = nvdla_core_rstn & w_load & w_win;

  assign w_real_pop = cmac2csb_resp_valid & (r_count != '0);
  assign w_head     = r_tags[r_rptr];

`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC);

  logic [TCW-1:0] r_tcnt;
  logic           r_timeout_err;
  logic           w_tmo;

  // A real response in the expiry cycle takes priority over the synthetic one.
  assign w_tmo     = ~cmac2csb_resp_valid & (r_count != '0) &
                     (r_tcnt == TCW'(TIMEOUT_CYC - 1));
  assign w_pop     = w_real_pop | w_tmo;
  assign w_resp_pd = w_tmo ? 34'h1_0000_0000 : cmac2csb_resp_pd;

  // The counter measures how long the current head has been waiting.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_tmo;
      if ((r_count == '0) || w_pop) r_tcnt <= '0;
      else                          r_tcnt <= r_tcnt + TCW'(1);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_pop     = w_real_pop;
  assign w_resp_pd = cmac2csb_resp_pd;
`endif

  // Control state: output valid, round-robin pointer, tag FIFO bookkeeping
  // and the registered response/orphan strobes.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_pvld        <= 1'b0;
      r_last        <= 1'b1;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_orphan      <= 1'b0;
    end else begin
      if (w_load)                 r_pvld <= 1'b1;
      else if (csb2cmac_req_prdy) r_pvld <= 1'b0;
      if (w_load) r_last <= w_win;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_resp0_valid <= w_pop & ~w_head;
      r_resp1_valid <= w_pop & w_head;
      r_orphan      <= cmac2csb_resp_valid & (r_count == '0);
    end
  end

  // Data registers carry no reset; they are only observed alongside a valid.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_load) r_pd <= w_win_pd;
    if (w_pop)  r_resp_pd <= w_resp_pd;
    if (w_push) r_tags[r_wptr] <= w_win;
  end

  assign csb2cmac_req_pvld = r_pvld;
  assign csb2cmac_req_pd   = r_pd;
  assign resp0_valid       = r_resp0_valid;
  assign resp1_valid       = r_resp1_valid;
  assign resp0_pd          = r_resp_pd;
  assign resp1_pd          = r_resp_pd;
  assign resp_orphan       = r_orphan;

endmodule

// File: tb/tb_nvdla_csb2cmac_arb.sv
// ---------------------------------------------------------------------------
// tb_nvdla_csb2cmac_arb
// Bench for nvdla_csb2cmac_arb. A queue-based model of the arbiter rules
// predicts the outputs every cycle; directed sequences add literal
// expectations for round-robin order, depth limit, routing, stalls and
// reset. Build with NVDLA_CSB2CMAC_ARB_TIMEOUT_EN to include the timeout case.
// ---------------------------------------------------------------------------
module tb_nvdla_csb2cmac_arb;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0Pvld, req1Pvld, req0Prdy, req1Prdy;
  logic [62:0] req0Pd, req1Pd;
  logic        dsPvld, dsPrdy;
  logic [62:0] dsPd;
  logic        respValid;
  logic [33:0] respPd;
  logic        resp0Valid, resp1Valid, respOrphan;
  logic [33:0] resp0Pd, resp1Pd;
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
  logic        timeoutErr;
`endif

  int checks = 0;
  int errors = 0;

  bit          mPvld;
  logic [62:0] mPd;
  bit          mLast;
  bit          mTags[$];
  bit          mR0, mR1, mOrph;
  logic [33:0] mRespPd;
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
  bit          mTerr;
  int          mAge;
`endif

  nvdla_csb2cmac_arb #(.OUTST_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .req0_pvld           (req0Pvld),
    .req0_prdy           (req0Prdy),
    .req0_pd             (req0Pd),
    .req1_pvld           (req1Pvld),
    .req1_prdy           (req1Prdy),
    .req1_pd             (req1Pd),
    .csb2cmac_req_pvld   (dsPvld),
    .csb2cmac_req_prdy   (dsPrdy),
    .csb2cmac_req_pd     (dsPd),
    .cmac2csb_resp_valid (respValid),
    .cmac2csb_resp_pd    (respPd),
    .resp0_valid         (resp0Valid),
    .resp0_pd            (resp0Pd),
    .resp1_valid         (resp1Valid),
    .resp1_pd            (resp1Pd),
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
    .timeout_err         (timeoutErr),
`endif
    .resp_orphan         (respOrphan)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Compares one observed value with its expectation and keeps the tallies.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge and waits one cycle.
  task automatic applyStimulus(input bit v0, input logic [62:0] pd0,
                               input bit v1, input logic [62:0] pd1,
                               input bit dr, input bit rv,
                               input logic [33:0] rpd);
    req0Pvld  = v0;
    req0Pd    = pd0;
    req1Pvld  = v1;
    req1Pd    = pd1;
    dsPrdy    = dr;
    respValid = rv;
    respPd    = rpd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [62:0] mkPd(input bit wr, input bit np,
                                       input logic [21:0] addr,
                                       input logic [31:0] wdat,
                                       input logic [6:0] hi);
    return {hi, np, wr, wdat, addr};
  endfunction

  function automatic bit needsResp(input logic [62:0] pd);
    return (pd[54] == 1'b0) || (pd[55] == 1'b1);
  endfunction

  // Model: on each falling edge, check the DUT against what the model
  // predicted, then advance the model by the rules for the coming edge.
  always @(negedge clk) begin
    bit n0, n1, e0, e1, ld, win, had, popped, head;
    if (!rstn) begin
      checkOutput("rst_req_pvld", dsPvld, 0);
      checkOutput("rst_resp0_valid", resp0Valid, 0);
      checkOutput("rst_resp1_valid", resp1Valid, 0);
      checkOutput("rst_orphan", respOrphan, 0);
      checkOutput("rst_req0_prdy", req0Prdy, 0);
      checkOutput("rst_req1_prdy", req1Prdy, 0);
      mPvld = 0; mLast = 1; mTags.delete();
      mR0 = 0; mR1 = 0; mOrph = 0;
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
      checkOutput("rst_timeout_err", timeoutErr, 0);
      mTerr = 0; mAge = 0;
`endif
    end else begin
      checkOutput("req_pvld", dsPvld, mPvld);
      if (mPvld) checkOutput("req_pd", dsPd, mPd);
      checkOutput("resp0_valid", resp0Valid, mR0);
      checkOutput("resp1_valid", resp1Valid, mR1);
      if (mR0) checkOutput("resp0_pd", resp0Pd, mRespPd);
      if (mR1) checkOutput("resp1_pd", resp1Pd, mRespPd);
      checkOutput("resp_orphan", respOrphan, mOrph);
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
      checkOutput("timeout_err", timeoutErr, mTerr);
`endif
      n0  = needsResp(req0Pd);
      n1  = needsResp(req1Pd);
      e0  = req0Pvld && (!n0 || mTags.size() < DEPTH);
      e1  = req1Pvld && (!n1 || mTags.size() < DEPTH);
      ld  = (!mPvld || dsPrdy) && (e0 || e1);
      win = (e0 && e1) ? !mLast : e1;
      checkOutput("req0_prdy", req0Prdy, ld && !win);
      checkOutput("req1_prdy", req1Prdy, ld && win);

      mR0 = 0; mR1 = 0; mOrph = 0; popped = 0;
      had = mTags.size() > 0;
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
      mTerr = 0;
`endif
      if (respValid) begin
        if (had) begin
          head = mTags.pop_front();
          popped = 1;
          mRespPd = respPd;
          if (head) mR1 = 1; else mR0 = 1;
        end else begin
          mOrph = 1;
        end
      end
`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
      else if (had && mAge == TMO - 1) begin
        head = mTags.pop_front();
        popped = 1;
        mRespPd = 34'h1_0000_0000;
        mTerr = 1;
        if (head) mR1 = 1; else mR0 = 1;
      end
      mAge = (!had || popped) ? 0 : mAge + 1;
`endif
      if (ld) begin
        mPvld = 1;
        mPd   = win ? req1Pd : req0Pd;
        mLast = win;
        if (needsResp(mPd)) mTags.push_back(win);
      end else if (dsPrdy) begin
        mPvld = 0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with literal expectations.
  initial begin
    logic [62:0] rd0, rd1, wr0, wr0b, wr1, npw;
    int found;
    rd0  = mkPd(0, 0, 22'h000100, 32'h0, 7'h11);
    rd1  = mkPd(0, 0, 22'h000200, 32'h0, 7'h22);
    wr0  = mkPd(1, 0, 22'h001234, 32'hCAFE0000, 7'h33);
    wr0b = mkPd(1, 0, 22'h001238, 32'hCAFE0001, 7'h44);
    wr1  = mkPd(1, 0, 22'h3ABCDE, 32'hDEADBEEF, 7'h7F);
    npw  = mkPd(1, 1, 22'h000300, 32'h12345678, 7'h55);

    rstn = 1'b0;
    applyStimulus(0, '0, 0, '0, 1, 0, '0);
    applyStimulus(1, rd0, 1, rd1, 1, 0, '0);
    applyStimulus(1, rd0, 1, rd1, 1, 0, '0);
    rstn = 1'b1;
    applyStimulus(0, '0, 0, '0, 1, 0, '0);

    // Round-robin between two reading requesters, req0 first.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, rd0, 1, rd1, 1, 0, '0);
      checkOutput("rr_grant", dsPd, (i % 2 == 0) ? rd0 : rd1);
    end
    checkOutput("rr_full_prdy0", req0Prdy, 0);
    checkOutput("rr_full_prdy1", req1Prdy, 0);

    // Responses route in order: tags 0,1,0,1.
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_00AA);
    checkOutput("route_resp0_valid", resp0Valid, 1);
    checkOutput("route_resp0_pd", resp0Pd, 34'h0_0000_00AA);
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_00BB);
    checkOutput("route_resp1_valid", resp1Valid, 1);
    checkOutput("route_resp0_quiet", resp0Valid, 0);
    checkOutput("route_resp1_pd", resp1Pd, 34'h0_0000_00BB);
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h1_0000_00CC);
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_00DD);
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_00EE);
    checkOutput("drain_orphan", respOrphan, 1);
    applyStimulus(0, '0, 0, '0, 1, 0, '0);

    // Posted write from req1: forwarded, nothing queued.
    applyStimulus(0, '0, 1, wr1, 1, 0, '0);
    checkOutput("posted_pvld", dsPvld, 1);
    checkOutput("posted_pd", dsPd, wr1);
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_0123);
    checkOutput("posted_no_tag", respOrphan, 1);

    // Depth limit: four reads accepted, the fifth waits for a response.
    for (int i = 0; i < 4; i++) applyStimulus(1, rd0, 0, '0, 1, 0, '0);
    checkOutput("depth_block", req0Prdy, 0);
    applyStimulus(1, rd0, 0, '0, 1, 0, '0);
    applyStimulus(1, rd0, 0, '0, 1, 1, 34'h0_0000_0055);
    checkOutput("depth_release", req0Prdy, 1);
    checkOutput("depth_resp0", resp0Valid, 1);
    applyStimulus(1, rd0, 0, '0, 1, 0, '0);
    checkOutput("depth_fifth_pd", dsPd, rd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, '0, 0, '0, 1, 1, 34'h100 + 34'(i));
    applyStimulus(0, '0, 0, '0, 1, 0, '0);

    // Downstream stall: payload held, nobody granted, then req1 wins.
    applyStimulus(1, wr0, 0, '0, 1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, wr0b, 1, wr1, 0, 0, '0);
      checkOutput("stall_pd", dsPd, wr0);
      checkOutput("stall_prdy0", req0Prdy, 0);
      checkOutput("stall_prdy1", req1Prdy, 0);
    end
    applyStimulus(1, wr0b, 1, wr1, 1, 0, '0);
    checkOutput("resume_pd", dsPd, wr1);
    applyStimulus(0, '0, 0, '0, 1, 0, '0);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 24; i++)
      applyStimulus(i % 3 != 0, (i % 4 == 0) ? npw : rd0,
                    i % 2 == 0, (i % 5 == 1) ? wr1 : rd1,
                    i % 5 != 2, i % 3 == 1, 34'h2_0000 + 34'(i));

    // Reset mid-operation discards queued tags.
    applyStimulus(1, rd0, 0, '0, 1, 0, '0);
    rstn = 1'b0;
    applyStimulus(0, '0, 0, '0, 1, 0, '0);
    applyStimulus(0, '0, 0, '0, 1, 0, '0);
    rstn = 1'b1;
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_0077);
    checkOutput("reset_discard", respOrphan, 1);
    applyStimulus(0, '0, 0, '0, 1, 0, '0);

`ifdef NVDLA_CSB2CMAC_ARB_TIMEOUT_EN
    // One read left unanswered times out after TMO cycles.
    applyStimulus(1, rd0, 0, '0, 1, 0, '0);
    found = 0;
    for (int n = 1; n <= TMO + 60; n++) begin
      applyStimulus(0, '0, 0, '0, 1, 0, '0);
      if (resp0Valid === 1'b1 && found == 0) begin
        found = n;
        checkOutput("timeout_resp_pd", resp0Pd, 34'h1_0000_0000);
        checkOutput("timeout_err_pulse", timeoutErr, 1);
      end
    end
    checkOutput("timeout_latency", found, TMO);
    applyStimulus(0, '0, 0, '0, 1, 1, 34'h0_0000_0099);
    checkOutput("timeout_late_orphan", respOrphan, 1);
    applyStimulus(0, '0, 0, '0, 1, 0, '0);
`else
    found = 0;
`endif

    applyStimulus(0, '0, 0, '0, 1, 0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
